// File: rtl/fifo_pkg.sv
// Shared types and helpers for the sync FIFO and its read-side controllers.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

  // Number of words a FIFO with the given address width can hold.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer carrying a data word plus its last tag.
// Handshake-only: a push is always taken; the upstream must guarantee room.
module fifo_rd_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  pop,
  output logic [1:0]            count
);

  // Entries are stored as {last, data}; head is the word presented downstream.
  logic [DATA_WIDTH:0] head_q, head_d;
  logic [DATA_WIDTH:0] tail_q, tail_d;
  logic [1:0]          count_q, count_d;
  logic [DATA_WIDTH:0] push_word;

  assign push_word = {push_last, push_data};
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q[DATA_WIDTH-1:0];
  assign out_last  = head_q[DATA_WIDTH];
  assign count     = count_q;

  // Next-state for the two entries: head only changes on a pop or when empty.
  always_comb begin
    pop     = (count_q != 2'd0) && out_ready;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push_valid, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_word;
        else                 tail_d = push_word;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_word;
        end else begin
          head_d = tail_q;
          tail_d = push_word;
        end
      end
      default: ;
    endcase
  end

  // Buffer registers; reset empties the buffer and zeroes the presented word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push_valid && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read controller for the sync FIFO: pulls BURST_LEN words (or whatever
// is present on flush) and streams them out on valid/ready with a last marker.
// Optional statistics counters are built when FIFO_BURST_READER_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for a full burst in the FIFO or a flush with data present
// BURST | issuing reads until beats_left reaches zero
// DRAIN | reads done; waiting for the last-tagged word to be accepted
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic [ADDR_WIDTH:0]   fifo_level,
  input  logic                  flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_BURST_READER_STATS_EN
  ,
  output logic [31:0]           stat_words,
  output logic [15:0]           stat_stalls
`endif
);

  localparam int                FIFO_DEPTH  = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] BURST_LEN_W = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0] BEAT_ONE    = (ADDR_WIDTH+1)'(1);

  generate
    if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH) begin : g_bad_burst_len
      $error("fifo_burst_reader: BURST_LEN must be within 1..FIFO_DEPTH");
    end
  endgenerate

  reader_state_e       state_q, state_d;
  logic [ADDR_WIDTH:0] beats_left_q, beats_left_d;
  logic                inflight_q, inflight_d;
  logic                inflight_last_q, inflight_last_d;
  logic                pop;
  logic [1:0]          buf_count;
  logic [2:0]          credit_sum;
  logic                credit_ok;
  logic                rd_last;

  // Words already buffered plus the one on its way, less the one leaving now,
  // must leave room for another read to land two cycles from now.
  assign credit_sum = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign credit_ok  = (credit_sum < 3'd2);
  assign busy       = (state_q != IDLE);

  // Read strobe and FSM next-state.
  always_comb begin
    fifo_rd_en      = (state_q == BURST) && (beats_left_q != '0) &&
                      (fifo_level != '0) && credit_ok;
    rd_last         = fifo_rd_en && (beats_left_q == BEAT_ONE);
    state_d         = state_q;
    beats_left_d    = beats_left_q;
    inflight_d      = fifo_rd_en;
    inflight_last_d = rd_last;
    case (state_q)
      IDLE: begin
        if (fifo_level >= BURST_LEN_W) begin
          state_d      = BURST;
          beats_left_d = BURST_LEN_W;
        end else if (flush && (fifo_level != '0)) begin
          state_d      = BURST;
          beats_left_d = fifo_level;
        end
      end
      BURST: begin
        if (fifo_rd_en) beats_left_d = beats_left_q - BEAT_ONE;
        if (rd_last)    state_d      = DRAIN;
      end
      DRAIN: begin
        if (pop && m_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, beat counter and in-flight read tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      beats_left_q    <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      beats_left_q    <= beats_left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  fifo_rd_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push_valid(inflight_q),
    .push_data (fifo_rdata),
    .push_last (inflight_last_q),
    .out_valid (m_valid),
    .out_ready (m_ready),
    .out_data  (m_data),
    .out_last  (m_last),
    .pop       (pop),
    .count     (buf_count)
  );

`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0] stat_words_q, stat_words_d;
  logic [15:0] stat_stalls_q, stat_stalls_d;

  assign stat_words  = stat_words_q;
  assign stat_stalls = stat_stalls_q;

  // Saturating counters for accepted words and backpressured cycles.
  always_comb begin
    stat_words_d  = stat_words_q;
    stat_stalls_d = stat_stalls_q;
    if (pop && (stat_words_q != '1))                    stat_words_d  = stat_words_q + 32'd1;
    if (m_valid && !m_ready && (stat_stalls_q != '1))   stat_stalls_d = stat_stalls_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_words_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_words_q  <= stat_words_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Scoreboard bench for fifo_burst_reader: a queue-backed FIFO model feeds the
// DUT, stimulus pushes expected {last,data} words, a negedge monitor checks them.
module tb_fifo_burst_reader;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rdata = '0;
  logic [AW:0]   fifo_level;
  logic          flush = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
`ifdef FIFO_BURST_READER_STATS_EN
  logic [31:0]   stat_words;
  logic [15:0]   stat_stalls;
`endif

  always #5 clk = ~clk;

  fifo_burst_reader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_rd_en (fifo_rd_en),
    .fifo_rdata (fifo_rdata),
    .fifo_level (fifo_level),
    .flush      (flush),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
`ifdef FIFO_BURST_READER_STATS_EN
    ,
    .stat_words (stat_words),
    .stat_stalls(stat_stalls)
`endif
  );

  // FIFO model: registered read data, level net of reads already taken.
  logic [DW-1:0] mem[$];
  logic [AW:0]   level_r = '0;
  logic          level_mask = 1'b0;
  assign fifo_level = level_mask ? '0 : level_r;

  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_rdata <= mem.pop_front();
      level_r    <= (AW+1)'(mem.size());
    end
  end

  logic [DW:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [DW-1:0] d, input logic last, input logic expect_it);
    mem.push_back(d);
    level_r <= (AW+1)'(mem.size());
    if (expect_it) exp_q.push_back({last, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((busy || exp_q.size() != 0) && n < max_cycles);
    check(name, {31'd0, (!busy && exp_q.size() == 0)}, 32'd1);
  endtask

  // Full-burst timing with m_ready high: reads in cycles 1-4, output 3-6, idle at 7.
  task automatic run_burst_timing(input string name, input logic [DW-1:0] base);
    logic [DW-1:0] w;
    tick();
    for (int i = 0; i < BL; i++) begin
      w = base + DW'(i);
      push_word(w, (i == BL - 1), 1'b1);
    end
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      check({name, "_rd_en"}, {31'd0, fifo_rd_en}, {31'd0, (c >= 1 && c <= 4)});
      check({name, "_busy"},  {31'd0, busy},       {31'd0, (c >= 1 && c <= 6)});
      check({name, "_valid"}, {31'd0, m_valid},    {31'd0, (c >= 3 && c <= 6)});
    end
  endtask

  // Monitor: pops the scoreboard on every accept and checks hold-under-stall.
  logic          prev_stall = 1'b0;
  logic [DW:0]   prev_word  = '0;
  logic [DW:0]   exp_word;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_word", {23'd0, m_last, m_data}, {23'd0, prev_word});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", {m_last, m_data});
        end else begin
          exp_word = exp_q.pop_front();
          check("word_data", {24'd0, m_data}, {24'd0, exp_word[DW-1:0]});
          check("word_last", {31'd0, m_last}, {31'd0, exp_word[DW]});
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_data};
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int rd_cnt;
    int n;
    logic [DW-1:0] w;

    // Reset values while rst is held.
    #2;
    check("rst_valid", {31'd0, m_valid},    32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_busy",  {31'd0, busy},       32'd0);
    check("rst_last",  {31'd0, m_last},     32'd0);
    check("rst_data",  {24'd0, m_data},     32'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();

    // Full burst 0x10..0x13 with cycle-accurate timing.
    run_burst_timing("t1", 8'h10);
    wait_idle("t1_idle", 5);

    // Flush with two words, then flush on an empty FIFO.
    tick();
    push_word(8'hA0, 1'b0, 1'b1);
    push_word(8'hA1, 1'b1, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_idle("t2_idle", 20);
    tick();
    flush = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("t2_empty_busy",  {31'd0, busy},       32'd0);
      check("t2_empty_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    end
    tick();
    flush = 1'b0;

    // Backpressure for five cycles once the first word is presented.
    m_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      w = 8'h20 + 8'(i);
      push_word(w, (i == 3), 1'b1);
    end
    rd_cnt = 0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_cnt++;
      if (c >= 3) check("t3_valid", {31'd0, m_valid}, 32'd1);
    end
    tick();
    m_ready = 1'b1;
    check("t3_reads_while_stalled", rd_cnt, 32'd2);
    wait_idle("t3_idle", 20);

    // FIFO level drops to zero mid-burst for four cycles.
    tick();
    for (int i = 0; i < 4; i++) begin
      w = 8'h30 + 8'(i);
      push_word(w, (i == 3), 1'b1);
    end
    tick();
    tick();
    level_mask = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("t4_gap_rd_en", {31'd0, fifo_rd_en}, 32'd0);
      check("t4_gap_busy",  {31'd0, busy},       32'd1);
    end
    tick();
    level_mask = 1'b0;
    @(negedge clk);
    check("t4_resume_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    wait_idle("t4_idle", 20);

    // Reset in the middle of a burst with a word presented and a read issuing.
    tick();
    push_word(8'h40, 1'b0, 1'b1);
    push_word(8'h41, 1'b0, 1'b0);
    push_word(8'h42, 1'b0, 1'b0);
    push_word(8'h43, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t5_pre_valid", {31'd0, m_valid},    32'd1);
    check("t5_pre_rd_en", {31'd0, fifo_rd_en}, 32'd1);
    check("t5_pre_busy",  {31'd0, busy},       32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_valid", {31'd0, m_valid},    32'd0);
    check("t5_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("t5_rst_busy",  {31'd0, busy},       32'd0);
    mem.delete();
    level_r <= '0;
    tick();
    tick();
    rst = 1'b0;
    check("t5_scoreboard_empty", exp_q.size(), 32'd0);
    run_burst_timing("t5_after", 8'h50);
    wait_idle("t5_idle", 5);

`ifdef FIFO_BURST_READER_STATS_EN
    // Statistics: eight words, exactly three stalled cycles.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ready = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      w = 8'h60 + 8'(i);
      push_word(w, (i == 3 || i == 7), 1'b1);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_valid && n < 20);
    check("t6_first_valid", {31'd0, m_valid}, 32'd1);
    repeat (2) @(negedge clk);
    tick();
    m_ready = 1'b1;
    wait_idle("t6_idle", 40);
    check("t6_stat_words",  stat_words,          32'd8);
    check("t6_stat_stalls", {16'd0, stat_stalls}, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
